mips_run_monitor: RTL and testbench

Synthesisable, parametrised run sequencer and checker for one or more MIPS CPU instances under test. It takes over the start-up, completion, timeout and result-check duties of a simulation-only harness and generalises them:
- N_CH independent channels;
- configurable data width, reset hold, start window and timeout;
- a detected no-start condition;
- per-channel cycle counts.

It sits between a top-level test controller (or FPGA harness) and the CPUs' `reset`, `clk_enable`, `active` and `register_v0` ports.

---
 rtl/mips_test_pkg.sv | 7 +
 rtl/mips_run_channel.sv | 101 ++++++++++
 rtl/mips_run_monitor.sv | 96 +++++++++
 tb/tb_mips_run_monitor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_test_pkg.sv
// Shared state encodings for the MIPS run sequencer and its per-channel checkers.
package mips_test_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} run_state_t;
  typedef enum logic [1:0] {WAIT, ACTIVE, FIN} ch_state_t;

endpackage

// File: rtl/mips_run_channel.sv
// One CPU channel: start-window watch, active-cycle count, timeout and v0 check.
module mips_run_channel
  import mips_test_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 32,
  parameter int START_WINDOW   = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              launch,
  input  logic              active,
  input  logic [DATA_W-1:0] register_v0,
  input  logic [DATA_W-1:0] expected,
  output logic              fin,
  output logic              pass,
  output logic              timeout,
  output logic              no_start,
  output logic [CNT_W-1:0]  cycles
);

  localparam int WIN_W = (START_WINDOW > 1) ? $clog2(START_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(START_WINDOW - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYCLES);

  ch_state_t        state, state_n;
  logic [WIN_W-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] cycles_n;
  logic             pass_n, timeout_n, no_start_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FIN;
      wcnt     <= '0;
      cycles   <= '0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      no_start <= 1'b0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      cycles   <= cycles_n;
      pass     <= pass_n;
      timeout  <= timeout_n;
      no_start <= no_start_n;
    end
  end

  // Completion is tested before the timeout limit so a falling active wins a tie.
  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    cycles_n   = cycles;
    pass_n     = pass;
    timeout_n  = timeout;
    no_start_n = no_start;
    if (clear) begin
      state_n    = FIN;
      wcnt_n     = '0;
      cycles_n   = '0;
      pass_n     = 1'b0;
      timeout_n  = 1'b0;
      no_start_n = 1'b0;
    end else if (launch) begin
      state_n = WAIT;
      wcnt_n  = '0;
    end else begin
      case (state)
        WAIT: begin
          if (active) begin
            state_n  = ACTIVE;
            cycles_n = CNT_W'(1);
          end else if (wcnt == WIN_LAST) begin
            state_n    = FIN;
            no_start_n = 1'b1;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (!active) begin
            state_n = FIN;
            pass_n  = (register_v0 == expected);
          end else if (cycles == TMO) begin
            state_n   = FIN;
            timeout_n = 1'b1;
            pass_n    = 1'b0;
          end else begin
            cycles_n = cycles + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fin = (state == FIN);

endmodule

// File: rtl/mips_run_monitor.sv
// Run sequencer: resets and enables the CPUs, then collects per-channel results.
module mips_run_monitor
  import mips_test_pkg::*;
#(
  parameter int N_CH           = 1,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 32,
  parameter int RESET_CYCLES   = 2,
  parameter int START_WINDOW   = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_CH-1:0]        cpu_active,
  input  logic [N_CH*DATA_W-1:0] register_v0,
  input  logic [N_CH*DATA_W-1:0] expected,
  output logic                   cpu_reset,
  output logic                   cpu_clk_enable,
  output logic                   done,
  output logic [N_CH-1:0]        pass,
  output logic [N_CH-1:0]        timeout,
  output logic [N_CH-1:0]        no_start,
  output logic [N_CH*CNT_W-1:0]  cycles,
  output logic                   all_pass
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  run_state_t        state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [N_CH-1:0]   fin;
  logic              clear, launch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_n = RUN;
        else                       hold_cnt_n = hold_cnt + 1'b1;
      end
      RUN: begin
        if (&fin) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign clear          = start && ((state == IDLE) || (state == DONE));
  assign launch         = (state == HOLD) && (hold_cnt == HOLD_LAST);
  assign cpu_reset      = (state == IDLE) || (state == HOLD);
  assign cpu_clk_enable = (state != IDLE);
  assign done           = (state == DONE);
  assign all_pass       = done & (&pass);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mips_run_channel #(
      .DATA_W        (DATA_W),
      .CNT_W         (CNT_W),
      .START_WINDOW  (START_WINDOW),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .launch     (launch),
      .active     (cpu_active[i]),
      .register_v0(register_v0[i*DATA_W +: DATA_W]),
      .expected   (expected[i*DATA_W +: DATA_W]),
      .fin        (fin[i]),
      .pass       (pass[i]),
      .timeout    (timeout[i]),
      .no_start   (no_start[i]),
      .cycles     (cycles[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: CPU activity model plus result scoreboard.
module tb_mips_run_monitor;

  localparam int N_CH = 2, DATA_W = 32, CNT_W = 16;
  localparam int RC = 2, SW = 4, TO = 50;

  logic                   clk = 1'b0;
  logic                   reset, start;
  logic [N_CH-1:0]        cpu_active = '0;
  logic [N_CH*DATA_W-1:0] register_v0, expected;
  logic                   cpu_reset, cpu_clk_enable, done, all_pass;
  logic [N_CH-1:0]        pass, timeout, no_start;
  logic [N_CH*CNT_W-1:0]  cycles;

  mips_run_monitor #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .RESET_CYCLES(RC), .START_WINDOW(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_active(cpu_active),
    .register_v0(register_v0), .expected(expected),
    .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable), .done(done),
    .pass(pass), .timeout(timeout), .no_start(no_start), .cycles(cycles),
    .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // CPU model: active goes high after edge run_r+dly, stays high for len samples.
  int          dly[N_CH], len[N_CH];
  bit          nost[N_CH];
  logic [31:0] vv[N_CH], ee[N_CH];
  int          run_r = 0;
  bit          run_on = 1'b0;

  always @(negedge clk)
    for (int i = 0; i < N_CH; i++)
      cpu_active[i] = run_on && !nost[i] && (edge_cnt >= run_r + dly[i]) &&
                      (edge_cnt < run_r + dly[i] + len[i]);

  typedef struct {
    logic [N_CH-1:0]       pass;
    logic [N_CH-1:0]       tmo;
    logic [N_CH-1:0]       ns;
    logic [N_CH*CNT_W-1:0] cyc;
    logic                  all_pass;
    int                    done_rel;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int d, input int l, input bit n,
                        input logic [31:0] v, input logic [31:0] e);
    dly[ch] = d; len[ch] = l; nost[ch] = n; vv[ch] = v; ee[ch] = e;
    register_v0[ch*DATA_W +: DATA_W] = v;
    expected[ch*DATA_W +: DATA_W]    = e;
  endtask

  task automatic do_run(input string name, input bit glitch);
    exp_t e, got;
    int   fin_rel, last, k, n;
    e.pass = '0; e.tmo = '0; e.ns = '0; e.cyc = '0; last = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (nost[i] || dly[i] >= SW) begin
        e.ns[i] = 1'b1;
        fin_rel = SW;
      end else if (len[i] > TO) begin
        e.tmo[i] = 1'b1;
        e.cyc[i*CNT_W +: CNT_W] = CNT_W'(TO);
        fin_rel = dly[i] + TO + 1;
      end else begin
        e.pass[i] = (vv[i] == ee[i]);
        e.cyc[i*CNT_W +: CNT_W] = CNT_W'(len[i]);
        fin_rel = dly[i] + len[i] + 1;
      end
      if (fin_rel > last) last = fin_rel;
    end
    e.done_rel = last + 1;
    e.all_pass = &e.pass;
    sb.push_back(e);

    @(negedge clk); start = 1'b1; k = edge_cnt + 1;
    @(negedge clk); start = 1'b0;
    check({name, ".clk_en_hold"}, 64'(cpu_clk_enable), 64'd1);
    n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check({name, ".release_edge"}, 64'(edge_cnt), 64'(k + RC));
    run_r = edge_cnt; run_on = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    got = sb.pop_front();
    check({name, ".done_edge"}, 64'(edge_cnt), 64'(run_r + got.done_rel));
    check({name, ".pass"},      64'(pass),     64'(got.pass));
    check({name, ".timeout"},   64'(timeout),  64'(got.tmo));
    check({name, ".no_start"},  64'(no_start), 64'(got.ns));
    check({name, ".cycles"},    64'(cycles),   64'(got.cyc));
    check({name, ".all_pass"},  64'(all_pass), 64'(got.all_pass));
    check({name, ".cpu_reset"}, 64'(cpu_reset), 64'd0);
    run_on = 1'b0;
    repeat (2) @(negedge clk);
    check({name, ".done_held"}, 64'({done, cpu_clk_enable}), 64'b11);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; register_v0 = '0; expected = '0;
    repeat (2) @(negedge clk);
    check("rst.ctrl", 64'({cpu_reset, cpu_clk_enable, done, all_pass}), 64'b1000);
    check("rst.flags", 64'({pass, timeout, no_start}), 64'd0);
    check("rst.cycles", 64'(cycles), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.ctrl", 64'({cpu_reset, cpu_clk_enable, done}), 64'b100);

    set_ch(0, 1, 20, 0, 32'h5, 32'h5); set_ch(1, 1, 20, 0, 32'h5, 32'h5);
    do_run("pass", 0);
    set_ch(0, 1, 20, 0, 32'h6, 32'h5); set_ch(1, 2, 15, 0, 32'h9, 32'h9);
    do_run("mismatch", 1);
    set_ch(0, 1, 1000, 0, 32'h7, 32'h7); set_ch(1, 1, 50, 0, 32'hff, 32'hff);
    do_run("timeout", 0);
    set_ch(0, 1, 0, 1, 32'h1, 32'h1); set_ch(1, 1, 0, 1, 32'h1, 32'h1);
    do_run("no_start", 0);
    set_ch(0, 1, 10, 0, 32'h1234, 32'h1234); set_ch(1, 1, 30, 0, 32'hbeef, 32'hbeef);
    do_run("two_ch", 0);
    set_ch(0, 3, 5, 0, 32'h8000_0005, 32'h0000_0005); set_ch(1, 4, 5, 0, 32'h2, 32'h2);
    do_run("window_edge", 0);

    // Reset pulled mid-run while both channels are active.
    set_ch(0, 1, 20, 0, 32'h5, 32'h5); set_ch(1, 1, 20, 0, 32'h5, 32'h5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("midrst.release", 64'(cpu_reset), 64'd0);
    run_r = edge_cnt; run_on = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst.ctrl", 64'({cpu_reset, cpu_clk_enable, done, all_pass}), 64'b1000);
    check("midrst.flags", 64'({pass, timeout, no_start}), 64'd0);
    check("midrst.cycles", 64'(cycles), 64'd0);
    reset = 1'b1; run_on = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.idle", 64'({cpu_reset, cpu_clk_enable}), 64'b10);
    do_run("after_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
